// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Circular FIFO between fetch and decode. Each entry holds a PC and its
//   instruction word. A taken branch (flush_F) discards all queued entries.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   imem_addr_F  PC offered by fetch
//   imem_data_F  instruction word at imem_addr_F
//   valid_F      fetch offers an entry this cycle
//   ready_F      queue can accept an entry (not full)
//   flush_F      discard all entries; beats push and pop
//   pc_D         PC of head entry (zero when empty)
//   instr_D      instruction of head entry (zero when empty)
//   valid_D      head entry present
//   ready_D      decode consumes the head entry
//   count        number of stored entries, 0..DEPTH
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [63:0]                imem_addr_F,
  input  logic [31:0]                imem_data_F,
  input  logic                       valid_F,
  output logic                       ready_F,
  input  logic                       flush_F,
  output logic [63:0]                pc_D,
  output logic [31:0]                instr_D,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Status depends only on stored occupancy, so ready_F never sees
  // ready_D or valid_F combinationally.
  assign ready_F = (count_q != CW'(DEPTH));
  assign valid_D = (count_q != '0);
  assign count   = count_q;

  assign push = valid_F && ready_F && !flush_F;
  assign pop  = valid_D && ready_D && !flush_F;

  assign pc_D    = valid_D ? pc_mem[rd_ptr]    : '0;
  assign instr_D = valid_D ? instr_mem[rd_ptr] : '0;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_F) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage is not reset or flushed; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= imem_addr_F;
      instr_mem[wr_ptr] <= imem_data_F;
    end
  end

endmodule
